pipe_stall_ctrl: RTL and testbench
==================================

Name: pipe_stall_ctrl

Overview:
- Central pipeline-control unit and producer of the 6-bit stall vector consumed by every pipeline register: pc, if_id, id_ex, ex_mem, mem_wb.
- Prioritises stall requests from ID (load-use), EX and MEM.
- Tracks a multi-cycle divide through a start/done handshake, counts stall cycles, and flags a watchdog error if the pipeline stays frozen too long.

Parameters:
- WDOG_LIMIT, 1024: consecutive stalled cycles after which watchdog_err sets.
- CNT_W, 32: width of the total stall-cycle counter.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- stallreq_id  in  1  ID stage requests stall (load-use hazard).
- stallreq_ex  in  1  EX stage requests stall (multi-cycle op issue cycle).
- stallreq_mem  in  1  MEM stage requests stall (data bus wait).
- div_start  in  1  EX launches a divide this cycle.
- div_done  in  1  divider result valid this cycle.
- stall  out  6  per-stage hold: bit0 pc, bit1 if, bit2 id, bit3 ex, bit4 mem, bit5 wb; 1 = STOP.
- div_busy  out  1  divide in flight.
- stall_cycles  out  CNT_W  total cycles with stall != 0, saturating.
- watchdog_err  out  1  sticky watchdog flag.

Behaviour:
- Stall vector: combinational, same-cycle, from inputs and registered state.
  - rst = 1: stall = 6'b000000.
  - else if stallreq_mem: 6'b011111.
  - else if stallreq_ex or div_busy: 6'b001111.
  - else if stallreq_id: 6'b000111.
  - else 6'b000000.
- Priority is strict: the highest-priority request wins and lower requests are absorbed.
- This encoding makes each pipeline register insert a bubble exactly where stall[n]=1 and stall[n+1]=0.
- Divide FSM, two states, registered:
  - IDLE -> BUSY when div_start = 1.
  - BUSY -> IDLE when div_done = 1 and div_start = 0.
  - BUSY with div_done = 1 and div_start = 1 stays BUSY (back-to-back divide).
  - div_done in IDLE is ignored.
  - div_start in BUSY without div_done is ignored (no nesting, no error).
  - div_busy = (state == BUSY), registered.
  - The issue cycle is covered by stallreq_ex from EX. The cycle div_done is seen, stall follows div_busy = 1 (still 001111); the next cycle releases.
- stall_cycles:
  - Increments by 1 at each posedge where the stall vector != 0.
  - Saturates at all-ones and never wraps.
  - Reset to 0.
- Watchdog:
  - Internal counter of consecutive stalled cycles, cleared on any cycle with stall == 0.
  - When the counter reaches WDOG_LIMIT-1 while still stalled, watchdog_err sets on that clock edge.
  - watchdog_err is sticky until rst.
  - The counter saturates at WDOG_LIMIT-1 after the error sets.
- Reset, including mid-divide:
  - state = IDLE, div_busy = 0, stall_cycles = 0, watchdog counter = 0, watchdog_err = 0.
  - stall = 0 while rst is high.
  - An in-flight divide is abandoned; a late div_done after reset is ignored.
- No combinational path from div_start/div_done to stall except through the registered div_busy.

Test Plan:
- Reset then idle 5 cycles -> stall = 000000, div_busy = 0, stall_cycles = 0, watchdog_err = 0.
- stallreq_id = 1 for 1 cycle -> stall = 000111 that cycle, then 000000; stall_cycles = 1.
- stallreq_id = 1 and stallreq_mem = 1 same cycle -> stall = 011111.
- stallreq_ex = 1 and stallreq_id = 1 same cycle -> stall = 001111.
- Divide handshake:
  - Stimulus: div_start + stallreq_ex at cycle 0, div_done at cycle 5.
  - Required: div_busy high cycles 1-5; stall = 001111 cycles 0-5 and 000000 at cycle 6; stall_cycles = 6.
  - Back-to-back: div_done and div_start together at cycle 5 -> div_busy stays 1.
- Reset mid-divide and watchdog:
  - Stimulus: rst pulse at cycle 3 of a divide.
  - Required: div_busy = 0 next cycle, and a later div_done leaves it 0.
  - Stimulus: with WDOG_LIMIT = 8, hold stallreq_id for 8 cycles.
  - Required: watchdog_err = 1 after the 8th stalled edge; it remains 1 after the stall clears.
- Saturation: with CNT_W = 4, stall for 20 cycles -> stall_cycles = 15, no wrap.

Source files
------------

// File: rtl/pipe_stall_ctrl_if.sv
// Handshake bundle between the pipeline stages and the central stall controller.
// The pipeline side uses the master modport and the controller uses the slave modport.
interface pipe_stall_ctrl_if #(
    parameter int CNT_W = 32
);
    logic             stallreq_id;
    logic             stallreq_ex;
    logic             stallreq_mem;
    logic             div_start;
    logic             div_done;
    logic [5:0]       stall;
    logic             div_busy;
    logic [CNT_W-1:0] stall_cycles;
    logic             watchdog_err;

    modport master (
        output stallreq_id,
        output stallreq_ex,
        output stallreq_mem,
        output div_start,
        output div_done,
        input  stall,
        input  div_busy,
        input  stall_cycles,
        input  watchdog_err
    );

    modport slave (
        input  stallreq_id,
        input  stallreq_ex,
        input  stallreq_mem,
        input  div_start,
        input  div_done,
        output stall,
        output div_busy,
        output stall_cycles,
        output watchdog_err
    );
endinterface

// File: rtl/pipe_stall_ctrl.sv
// Central pipeline stall controller. It builds a prioritised per-stage hold vector and tracks an in-flight divide.
// It also counts stalled cycles and raises a sticky watchdog flag when the pipeline stays frozen.
module pipe_stall_ctrl #(
    parameter int WDOG_LIMIT = 1024,
    parameter int CNT_W      = 32
) (
    input logic                clk,
    input logic                rst,
    pipe_stall_ctrl_if.slave   bus
);
    localparam int WD_W = (WDOG_LIMIT > 2) ? $clog2(WDOG_LIMIT) : 1;
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(WDOG_LIMIT - 1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
    logic [WD_W-1:0]  wd_cnt_q, wd_cnt_d;
    logic             wd_err_q, wd_err_d;
    logic [5:0]       stall_s;
    logic             stalled_s;
    logic             div_busy_s;

    // The divide engine only reaches stall through the registered busy state
    assign div_busy_s = (state_q == ST_BUSY);

    // Strict priority hold vector; the lowest clear bit above a set bit marks where a bubble is inserted
    always_comb begin
        stall_s = 6'b000000;
        if (rst) begin
            stall_s = 6'b000000;
        end else if (bus.stallreq_mem) begin
            stall_s = 6'b011111;
        end else if (bus.stallreq_ex || div_busy_s) begin
            stall_s = 6'b001111;
        end else if (bus.stallreq_id) begin
            stall_s = 6'b000111;
        end else begin
            stall_s = 6'b000000;
        end
    end

    assign stalled_s = (stall_s != 6'b000000);

    // Divide tracker: done together with start keeps the engine busy for the next divide
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.div_start) begin
                    state_d = ST_BUSY;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (bus.div_done && !bus.div_start) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_BUSY;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Saturating total stall counter and the consecutive-stall watchdog
    always_comb begin
        stall_cycles_d = stall_cycles_q;
        wd_cnt_d       = wd_cnt_q;
        wd_err_d       = wd_err_q;
        if (stalled_s) begin
            if (stall_cycles_q != {CNT_W{1'b1}}) begin
                stall_cycles_d = stall_cycles_q + CNT_W'(1);
            end else begin
                stall_cycles_d = stall_cycles_q;
            end
            if (wd_cnt_q == WD_MAX) begin
                wd_err_d = 1'b1;
                wd_cnt_d = wd_cnt_q;
            end else begin
                wd_cnt_d = wd_cnt_q + WD_W'(1);
            end
        end else begin
            wd_cnt_d = {WD_W{1'b0}};
        end
    end

    // State registers with synchronous reset; reset abandons any in-flight divide
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            stall_cycles_q <= {CNT_W{1'b0}};
            wd_cnt_q       <= {WD_W{1'b0}};
            wd_err_q       <= 1'b0;
        end else begin
            state_q        <= state_d;
            stall_cycles_q <= stall_cycles_d;
            wd_cnt_q       <= wd_cnt_d;
            wd_err_q       <= wd_err_d;
        end
    end

    assign bus.stall        = stall_s;
    assign bus.div_busy     = div_busy_s;
    assign bus.stall_cycles = stall_cycles_q;
    assign bus.watchdog_err = wd_err_q;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed bench for pipe_stall_ctrl with a small watchdog limit and a narrow counter.
// Inputs change 1ns after each rising edge. Checks happen before the next rising edge.
module tb_pipe_stall_ctrl;
    localparam int WDOG_LIMIT = 8;
    localparam int CNT_W      = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    pipe_stall_ctrl_if #(.CNT_W(CNT_W)) bus ();

    pipe_stall_ctrl #(.WDOG_LIMIT(WDOG_LIMIT), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
            $error("%s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic id, input logic ex, input logic mem,
                         input logic ds, input logic dd);
        bus.stallreq_id  = id;
        bus.stallreq_ex  = ex;
        bus.stallreq_mem = mem;
        bus.div_start    = ds;
        bus.div_done     = dd;
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        rst = 1'b0;
        #1;
    endtask

    initial begin
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("stall_in_reset", 32'(bus.stall), 32'h00);
        tick();
        do_reset();

        // Idle after reset
        for (int i = 0; i < 5; i++) tick();
        chk("idle_stall", 32'(bus.stall), 32'h00);
        chk("idle_busy", 32'(bus.div_busy), 32'h0);
        chk("idle_cycles", 32'(bus.stall_cycles), 32'h0);
        chk("idle_wdog", 32'(bus.watchdog_err), 32'h0);

        // Single-cycle load-use stall
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("id_stall", 32'(bus.stall), 32'h07);
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("id_release", 32'(bus.stall), 32'h00);
        chk("id_cycles", 32'(bus.stall_cycles), 32'h1);

        // Priority resolution
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("mem_over_id", 32'(bus.stall), 32'h1f);
        tick();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("ex_over_id", 32'(bus.stall), 32'h0f);
        tick();
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("mem_over_ex", 32'(bus.stall), 32'h1f);
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("prio_cycles", 32'(bus.stall_cycles), 32'h4);

        // Divide handshake: start at cycle 0, done at cycle 5
        do_reset();
        drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("div_c0_stall", 32'(bus.stall), 32'h0f);
        chk("div_c0_busy", 32'(bus.div_busy), 32'h0);
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int c = 1; c <= 4; c++) begin
            chk("div_mid_busy", 32'(bus.div_busy), 32'h1);
            chk("div_mid_stall", 32'(bus.stall), 32'h0f);
            tick();
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("div_c5_busy", 32'(bus.div_busy), 32'h1);
        chk("div_c5_stall", 32'(bus.stall), 32'h0f);
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("div_c6_busy", 32'(bus.div_busy), 32'h0);
        chk("div_c6_stall", 32'(bus.stall), 32'h00);
        chk("div_cycles", 32'(bus.stall_cycles), 32'h6);

        // Done in idle is ignored
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("done_idle_busy", 32'(bus.div_busy), 32'h0);

        // Back-to-back divide: done and start together at cycle 5
        do_reset();
        drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int c = 1; c <= 4; c++) tick();
        drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("b2b_busy", 32'(bus.div_busy), 32'h1);
        chk("b2b_stall", 32'(bus.stall), 32'h0f);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("b2b_end_busy", 32'(bus.div_busy), 32'h0);

        // Reset mid-divide, then a late done
        do_reset();
        drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        rst = 1'b1;
        #1;
        chk("rst_mid_stall", 32'(bus.stall), 32'h00);
        tick();
        rst = 1'b0;
        #1;
        chk("rst_mid_busy", 32'(bus.div_busy), 32'h0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("late_done_busy", 32'(bus.div_busy), 32'h0);
        chk("late_done_stall", 32'(bus.stall), 32'h00);

        // Watchdog cleared by a single unstalled cycle
        do_reset();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        chk("wdog_cleared", 32'(bus.watchdog_err), 32'h0);

        // Watchdog sets on the eighth consecutive stalled edge and sticks
        do_reset();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) tick();
        chk("wdog_7", 32'(bus.watchdog_err), 32'h0);
        tick();
        chk("wdog_8", 32'(bus.watchdog_err), 32'h1);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        chk("wdog_sticky", 32'(bus.watchdog_err), 32'h1);

        // Stall counter saturates at all-ones
        do_reset();
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 14; i++) tick();
        chk("sat_14", 32'(bus.stall_cycles), 32'he);
        for (int i = 0; i < 6; i++) tick();
        chk("sat_20", 32'(bus.stall_cycles), 32'hf);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        chk("sat_hold", 32'(bus.stall_cycles), 32'hf);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
